tdc_timestamp_assembler: RTL and testbench
==========================================

Name: tdc_timestamp_assembler

Overview:
- Sits directly downstream of the fine TDC + thermometer encoder stage.
- Runs a free-running coarse counter and, on each fine-valid strobe, latches a coarse/fine timestamp pair, compensating for the encoder pipeline latency.
- Buffers timestamps in a small FIFO with a valid/ready output to the readout/UART stage, and counts events dropped on overflow.

Parameters:
- FINE_BITS, 6, width of the fine code from the encoder.
- COARSE_BITS, 24, width of the coarse clock-cycle counter.
- PIPE_LAT, 4, clock cycles from the hit's capturing clock edge to the fine_valid strobe; subtracted from the coarse count.
- DEPTH_LOG2, 3, log2 of FIFO depth (8 entries).
- DROP_BITS, 16, width of the saturating drop counter.

Ports:
- clock, input, 1, single system clock; everything is on the rising edge.
- reset, input, 1, synchronous, active-low reset.
- enable, input, 1, 1 = accept events and run the coarse counter; 0 = ignore fine_valid and hold the coarse counter.
- fine_valid, input, 1, single-cycle strobe: value_fine holds a new result.
- value_fine, input, FINE_BITS, fine code from the encoder.
- clear, input, 1, synchronous soft clear: flushes the FIFO and zeroes the coarse and drop counters.
- out_data, output, COARSE_BITS+FINE_BITS, timestamp {coarse_adj, fine}.
- out_valid, output, 1, FIFO non-empty.
- out_ready, input, 1, consumer accepts out_data this cycle.
- drop_count, output, DROP_BITS, number of events lost to a full FIFO; saturates.
- fifo_level, output, DEPTH_LOG2+1, current occupancy.

Behaviour:
- Reset (reset==0 at a clock edge):
  - coarse=0, FIFO empty, out_valid=0, out_data=0, drop_count=0, fifo_level=0.
  - Reset overrides every other input in the same cycle.
  - Reset mid-transfer discards all buffered data. No partial word is ever presented.
- clear==1: same effect as reset but does not affect out_data. Clear has priority over push and pop in the same cycle.
- Coarse counter:
  - Increments by 1 every cycle while enable==1.
  - Wraps modulo 2^COARSE_BITS with no flag.
- Capture:
  - When fine_valid==1 and enable==1, form coarse_adj = (coarse − PIPE_LAT) mod 2^COARSE_BITS, using the coarse value of that same cycle.
  - value_fine is stored unmodified; calibration is done downstream.
  - Word = {coarse_adj, value_fine}.
- Push: occurs 1 cycle after the capture. The word is registered, then written.
  - Capture-to-out_valid latency when the FIFO is empty: 2 cycles.
- Back-to-back fine_valid on consecutive cycles must each be captured; no event may be lost while space exists.
- FIFO:
  - Pop when out_valid && out_ready.
  - out_data is the head entry, valid whenever out_valid==1, and stable while out_valid && !out_ready.
  - Ordering is strictly FIFO.
- Full FIFO:
  - A push with no simultaneous pop is dropped and drop_count increments.
  - A push with a simultaneous pop is accepted and the level is unchanged.
  - drop_count saturates at 2^DROP_BITS−1.
- Empty FIFO with a simultaneous push: out_valid rises the next cycle. There is no combinational fall-through.
- enable==0: a pending registered word from the previous cycle still completes its push.
- fifo_level: exact occupancy, updated each cycle, range 0..2^DEPTH_LOG2.

Decomposition:
- Shared package (tdc_pkg):
  - Constants FINE_BITS and COARSE_BITS, with defaults matching the encoder.
  - The timestamp word width, TS_BITS = COARSE_BITS+FINE_BITS.
  - Field offsets FINE_LSB=0 and COARSE_LSB=FINE_BITS.
- Sub-module sync_fifo_fwft, a generic synchronous FIFO:
  - Parameters WIDTH and DEPTH_LOG2.
  - Ports push, pop, full, empty, level, head.
  - Uses the same reset/clear semantics.
- The top level holds the coarse counter, capture register, drop counter and glue.

Test Plan:
- Reset/idle: hold reset low 3 cycles, then release with enable=1 and no hits → out_valid=0, drop_count=0. After 10 cycles the internal coarse count is 10, checked via one hit: fine_valid at coarse=10 with value_fine=0x15 and PIPE_LAT=4 → out_data={24'd6,6'h15} two cycles later.
- Coarse wrap: force coarse near the top with COARSE_BITS=4, PIPE_LAT=4; hit when coarse=2 → coarse_adj=14 (wraps correctly).
- Back-to-back: fine_valid on 5 consecutive cycles with values 1..5 and out_ready=1 → 5 words in order, coarse fields consecutive, no drops.
- Overflow: out_ready=0, 10 hits, DEPTH=8 → fifo_level=8, drop_count=2. Raise out_ready → the first 8 words drain in order.
- Full with simultaneous pop: FIFO full, out_ready=1 and fine_valid in the same push cycle → push accepted, level stays 8, drop_count unchanged.
- Clear/reset mid-operation: 3 words buffered, out_ready=0; pulse clear → next cycle out_valid=0, fifo_level=0, drop_count=0. Repeat with reset low → same result and out_data=0.

Source files
------------

// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pkg
// Description : Shared constants for the TDC timestamp path. Default field
//               widths match the fine TDC thermometer encoder, and the
//               timestamp word layout is {coarse, fine} with fine in the LSBs.
// Contents    : FINE_BITS, COARSE_BITS  - default field widths
//               TS_BITS                 - timestamp word width
//               FINE_LSB, COARSE_LSB    - field offsets inside the word
// Revision    : 1.0 - initial release
// ============================================================================
package tdc_pkg;

   localparam int FINE_BITS   = 6;
   localparam int COARSE_BITS = 24;
   localparam int TS_BITS     = COARSE_BITS + FINE_BITS;

   localparam int FINE_LSB    = 0;
   localparam int COARSE_LSB  = FINE_BITS;

endpackage : tdc_pkg
`default_nettype wire

// File: rtl/tdc_timestamp_assembler_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Generic single-clock FIFO with a registered head output.
//               The head register presents the oldest entry whenever the FIFO
//               is non-empty; a word pushed into an empty FIFO becomes visible
//               on the following cycle (no combinational fall-through).
//               A push into a full FIFO is accepted only when a pop happens in
//               the same cycle.
// Ports       : clk_i       - clock, rising edge
//               rst_ni      - synchronous active-low reset (clears head too)
//               clear_i     - synchronous flush, head register left untouched
//               push_i      - write push_data_i (ignored when full w/o pop)
//               push_data_i - data to write
//               pop_i       - consume head (ignored when empty)
//               full_o      - FIFO holds 2**DEPTH_LOG2 entries
//               empty_o     - FIFO holds no entries
//               level_o     - exact occupancy 0..2**DEPTH_LOG2
//               head_o      - oldest entry, valid while !empty_o
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
   parameter int WIDTH      = 30,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      push_data_i,
   input  logic                  pop_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic [WIDTH-1:0]      head_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   lvl_t;

   localparam lvl_t LEVEL_FULL = lvl_t'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];

   ptr_t             wr_ptr_q, wr_ptr_d;
   ptr_t             rd_ptr_q, rd_ptr_d;
   lvl_t             level_q,  level_d;
   logic [WIDTH-1:0] head_q,   head_d;

   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   lvl_t             w_kept;

   assign w_full  = (level_q == LEVEL_FULL);
   assign w_empty = (level_q == '0);
   assign w_pop   = pop_i && !w_empty;
   // A pop frees the slot the push needs, so full+pop+push is legal.
   assign w_push  = push_i && (!w_full || w_pop);

   // Entries that survive the pop; zero means the new head is the pushed word.
   assign w_kept  = level_q - lvl_t'(w_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + ptr_t'(w_push);
      rd_ptr_d = rd_ptr_q + ptr_t'(w_pop);
      level_d  = w_kept + lvl_t'(w_push);
      head_d   = head_q;
      if (level_d != '0) begin
         if (w_kept == '0) begin
            head_d = push_data_i;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (rst_ni && !clear_i && w_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign full_o  = w_full;
   assign empty_o = w_empty;
   assign level_o = level_q;
   assign head_o  = head_q;

endmodule : sync_fifo_fwft
`default_nettype wire

// File: rtl/tdc_timestamp_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tdc_timestamp_assembler
// Description : Free-running coarse counter plus capture/buffer stage behind
//               the fine TDC encoder. Each fine_valid strobe latches
//               {coarse - PIPE_LAT, value_fine}; the word is registered and
//               pushed into a small FIFO one cycle later. Words lost to a full
//               FIFO are counted in a saturating drop counter.
// Ports       : clock_i       - system clock, rising edge
//               reset_i       - synchronous active-low reset
//               enable_i      - run coarse counter and accept hits
//               fine_valid_i  - single-cycle strobe, value_fine_i is new
//               value_fine_i  - fine code from the encoder
//               clear_i       - soft clear: flush FIFO, zero counters
//               out_data_o    - timestamp {coarse_adj, fine}
//               out_valid_o   - FIFO non-empty
//               out_ready_i   - consumer takes out_data_o this cycle
//               drop_count_o  - saturating count of dropped events
//               fifo_level_o  - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_timestamp_assembler #(
   parameter int FINE_BITS   = tdc_pkg::FINE_BITS,
   parameter int COARSE_BITS = tdc_pkg::COARSE_BITS,
   parameter int PIPE_LAT    = 4,
   parameter int DEPTH_LOG2  = 3,
   parameter int DROP_BITS   = 16
) (
   input  logic                            clock_i,
   input  logic                            reset_i,
   input  logic                            enable_i,
   input  logic                            fine_valid_i,
   input  logic [FINE_BITS-1:0]            value_fine_i,
   input  logic                            clear_i,
   output logic [COARSE_BITS+FINE_BITS-1:0] out_data_o,
   output logic                            out_valid_o,
   input  logic                            out_ready_i,
   output logic [DROP_BITS-1:0]            drop_count_o,
   output logic [DEPTH_LOG2:0]             fifo_level_o
);

   import tdc_pkg::*;

   localparam int TS_W = COARSE_BITS + FINE_BITS;

   typedef logic [COARSE_BITS-1:0] coarse_t;
   typedef logic [DROP_BITS-1:0]   drop_t;

   localparam coarse_t PIPE_LAT_C = coarse_t'(PIPE_LAT);
   localparam drop_t   DROP_MAX   = '1;

   coarse_t          coarse_q,    coarse_d;
   logic             cap_valid_q, cap_valid_d;
   logic [TS_W-1:0]  cap_word_q,  cap_word_d;
   drop_t            drop_q,      drop_d;

   coarse_t          w_coarse_adj;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic             w_pop;
   logic             w_drop;

   // The hit was sampled PIPE_LAT edges before the strobe; wraps modulo 2**N.
   assign w_coarse_adj = coarse_q - PIPE_LAT_C;

   assign w_pop  = !w_fifo_empty && out_ready_i;
   assign w_drop = cap_valid_q && w_fifo_full && !w_pop;

   always_comb begin
      coarse_d    = coarse_q;
      cap_valid_d = 1'b0;
      cap_word_d  = cap_word_q;
      drop_d      = drop_q;
      if (clear_i) begin
         coarse_d = '0;
         drop_d   = '0;
      end else begin
         if (enable_i) begin
            coarse_d = coarse_q + coarse_t'(1);
         end
         if (enable_i && fine_valid_i) begin
            cap_valid_d = 1'b1;
            cap_word_d  = {w_coarse_adj, value_fine_i};
         end
         if (w_drop && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + drop_t'(1);
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         coarse_q    <= '0;
         cap_valid_q <= 1'b0;
         cap_word_q  <= '0;
         drop_q      <= '0;
      end else begin
         coarse_q    <= coarse_d;
         cap_valid_q <= cap_valid_d;
         cap_word_q  <= cap_word_d;
         drop_q      <= drop_d;
      end
   end

   sync_fifo_fwft #(
      .WIDTH      (TS_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk_i       (clock_i),
      .rst_ni      (reset_i),
      .clear_i     (clear_i),
      .push_i      (cap_valid_q),
      .push_data_i (cap_word_q),
      .pop_i       (out_ready_i),
      .full_o      (w_fifo_full),
      .empty_o     (w_fifo_empty),
      .level_o     (fifo_level_o),
      .head_o      (out_data_o)
   );

   assign out_valid_o  = !w_fifo_empty;
   assign drop_count_o = drop_q;

endmodule : tdc_timestamp_assembler
`default_nettype wire

// File: tb/tb_tdc_timestamp_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdc_timestamp_assembler
// Description : Self-checking bench. A queue-based reference model tracks the
//               coarse count, the one-cycle capture delay, FIFO contents and
//               the drop count; directed scenarios plus a randomized run are
//               compared against it. A second instance with a 4-bit coarse
//               counter exercises wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_timestamp_assembler;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance (default widths)
   logic        reset_n, enable, fine_valid, clear, out_ready;
   logic [5:0]  value_fine;
   logic [29:0] out_data;
   logic        out_valid;
   logic [15:0] drop_count;
   logic [3:0]  fifo_level;

   // Wrap instance (COARSE_BITS = 4)
   logic        reset2_n, enable2, fv2, clear2, ready2;
   logic [5:0]  vf2;
   logic [9:0]  out_data2;
   logic        out_valid2;
   logic [15:0] drop2;
   logic [3:0]  level2;

   tdc_timestamp_assembler #(
      .FINE_BITS(6), .COARSE_BITS(24), .PIPE_LAT(4), .DEPTH_LOG2(3), .DROP_BITS(16)
   ) dut (
      .clock_i(clk), .reset_i(reset_n), .enable_i(enable), .fine_valid_i(fine_valid),
      .value_fine_i(value_fine), .clear_i(clear), .out_data_o(out_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .drop_count_o(drop_count),
      .fifo_level_o(fifo_level)
   );

   tdc_timestamp_assembler #(
      .FINE_BITS(6), .COARSE_BITS(4), .PIPE_LAT(4), .DEPTH_LOG2(3), .DROP_BITS(16)
   ) dut_wrap (
      .clock_i(clk), .reset_i(reset2_n), .enable_i(enable2), .fine_valid_i(fv2),
      .value_fine_i(vf2), .clear_i(clear2), .out_data_o(out_data2),
      .out_valid_o(out_valid2), .out_ready_i(ready2), .drop_count_o(drop2),
      .fifo_level_o(level2)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [29:0] mq[$];
   logic        m_pend_v = 1'b0;
   logic [29:0] m_pend   = '0;
   logic [23:0] m_coarse = '0;
   int          m_drop   = 0;

   // Advance model by one clock edge using the inputs currently driven,
   // then let the DUT take the same edge and settle.
   task automatic step();
      bit pop;
      int size_before;
      if (!reset_n || clear) begin
         mq.delete();
         m_pend_v = 1'b0;
         m_coarse = '0;
         m_drop   = 0;
      end else begin
         size_before = mq.size();
         pop = (size_before > 0) && out_ready;
         if (pop) void'(mq.pop_front());
         if (m_pend_v) begin
            if (size_before == 8 && !pop) begin
               if (m_drop < 65535) m_drop++;
            end else begin
               mq.push_back(m_pend);
            end
         end
         m_pend_v = enable && fine_valid;
         m_pend   = {m_coarse - 24'd4, value_fine};
         if (enable) m_coarse = m_coarse + 24'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; reset2_n = 1'b0;
      repeat (3) step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
      n_cmp++; if (out_data !== 30'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
      reset_n = 1'b1; enable = 1'b1;
      repeat (10) step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", out_valid); end
      n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL idle_drop: got %0d want 0", drop_count); end
      fine_valid = 1'b1; value_fine = 6'h15;
      step();
      fine_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat1_valid: got %b want 0", out_valid); end
      step();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lat2_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_data !== {24'd6, 6'h15}) begin n_err++; $display("FAIL first_word: got %h want %h", out_data, {24'd6, 6'h15}); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL first_pop: got valid %b want 0", out_valid); end
   endtask

   task automatic test_coarse_wrap();
      reset2_n = 1'b0; enable2 = 1'b0; fv2 = 1'b0; ready2 = 1'b0;
      repeat (2) step();
      reset2_n = 1'b1; enable2 = 1'b1;
      repeat (18) step();          // coarse: 18 mod 16 = 2
      fv2 = 1'b1; vf2 = 6'h2A;
      step();
      fv2 = 1'b0;
      repeat (2) step();
      n_cmp++; if (out_valid2 !== 1'b1) begin n_err++; $display("FAIL wrap_valid: got %b want 1", out_valid2); end
      n_cmp++; if (out_data2 !== {4'd14, 6'h2A}) begin n_err++; $display("FAIL wrap_word: got %h want %h", out_data2, {4'd14, 6'h2A}); end
      ready2 = 1'b1;
      step();                      // pop; coarse now 6
      ready2 = 1'b0;
      fv2 = 1'b1; vf2 = 6'h01;
      step();
      fv2 = 1'b0;
      repeat (2) step();
      n_cmp++; if (out_data2 !== {4'd2, 6'h01}) begin n_err++; $display("FAIL wrap_word2: got %h want %h", out_data2, {4'd2, 6'h01}); end
      enable2 = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [29:0] got[$];
      logic [23:0] c0;
      clear = 1'b1; step(); clear = 1'b0;
      out_ready = 1'b1;
      c0 = m_coarse - 24'd4;
      for (int cyc = 0; cyc < 16; cyc++) begin
         fine_valid = (cyc < 5);
         value_fine = 6'(cyc + 1);
         if (out_valid) got.push_back(out_data);
         step();
      end
      fine_valid = 1'b0;
      n_cmp++; if (got.size() != 5) begin n_err++; $display("FAIL b2b_count: got %0d words want 5", got.size()); end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== {c0 + 24'(i), 6'(i + 1)}) begin
            n_err++; $display("FAIL b2b_word%0d: got %h want %h", i, got[i], {c0 + 24'(i), 6'(i + 1)});
         end
      end
      n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL b2b_drop: got %0d want 0", drop_count); end
      out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      logic [29:0] got[$];
      logic [23:0] c0;
      clear = 1'b1; step(); clear = 1'b0;
      out_ready = 1'b0;
      c0 = m_coarse - 24'd4;
      for (int i = 0; i < 10; i++) begin
         fine_valid = 1'b1; value_fine = 6'(10 + i);
         step();
      end
      fine_valid = 1'b0;
      repeat (2) step();
      n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
      n_cmp++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL ovf_drop: got %0d want 2", drop_count); end
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (out_valid) got.push_back(out_data);
         step();
      end
      out_ready = 1'b0;
      n_cmp++; if (got.size() != 8) begin n_err++; $display("FAIL ovf_drain_count: got %0d want 8", got.size()); end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== {c0 + 24'(i), 6'(10 + i)}) begin
            n_err++; $display("FAIL ovf_word%0d: got %h want %h", i, got[i], {c0 + 24'(i), 6'(10 + i)});
         end
      end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got valid %b want 0", out_valid); end
   endtask

   task automatic test_full_pop();
      logic [23:0] c0;
      clear = 1'b1; step(); clear = 1'b0;
      out_ready = 1'b0;
      c0 = m_coarse - 24'd4;
      for (int i = 0; i < 8; i++) begin
         fine_valid = 1'b1; value_fine = 6'(20 + i);
         step();
      end
      fine_valid = 1'b0;
      repeat (2) step();
      n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL fp_prefill: got %0d want 8", fifo_level); end
      fine_valid = 1'b1; value_fine = 6'h3F;
      step();                      // capture
      fine_valid = 1'b0; out_ready = 1'b1;
      step();                      // push and pop together
      out_ready = 1'b0;
      n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL fp_level: got %0d want 8", fifo_level); end
      n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL fp_drop: got %0d want 0", drop_count); end
      n_cmp++; if (out_data !== {c0 + 24'd1, 6'd21}) begin n_err++; $display("FAIL fp_head: got %h want %h", out_data, {c0 + 24'd1, 6'd21}); end
      fine_valid = 1'b1; value_fine = 6'h2E;
      step();
      fine_valid = 1'b0;
      repeat (2) step();
      n_cmp++; if (drop_count !== 16'd1) begin n_err++; $display("FAIL fp_drop_nopop: got %0d want 1", drop_count); end
      n_cmp++; if (out_data !== {c0 + 24'd1, 6'd21}) begin n_err++; $display("FAIL fp_head_stable: got %h want %h", out_data, {c0 + 24'd1, 6'd21}); end
   endtask

   task automatic test_clear_reset();
      logic [23:0] c0;
      clear = 1'b1; step(); clear = 1'b0;
      out_ready = 1'b0;
      c0 = m_coarse - 24'd4;
      for (int i = 0; i < 10; i++) begin
         fine_valid = 1'b1; value_fine = 6'(30 + i);
         step();
      end
      fine_valid = 1'b0;
      repeat (2) step();
      n_cmp++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL clr_pre_drop: got %0d want 2", drop_count); end
      clear = 1'b1; step(); clear = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b want 0", out_valid); end
      n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL clr_level: got %0d want 0", fifo_level); end
      n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL clr_drop: got %0d want 0", drop_count); end
      n_cmp++; if (out_data !== {c0, 6'd30}) begin n_err++; $display("FAIL clr_data_kept: got %h want %h", out_data, {c0, 6'd30}); end
      for (int i = 0; i < 3; i++) begin
         fine_valid = 1'b1; value_fine = 6'(40 + i);
         step();
      end
      fine_valid = 1'b0;
      repeat (2) step();
      n_cmp++; if (fifo_level !== 4'd3) begin n_err++; $display("FAIL rst_pre_level: got %0d want 3", fifo_level); end
      reset_n = 1'b0; step(); reset_n = 1'b1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
      n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
      n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL rst_drop: got %0d want 0", drop_count); end
      n_cmp++; if (out_data !== 30'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", out_data); end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 800; cyc++) begin
         enable     = ($urandom % 8) != 0;
         fine_valid = $urandom % 2;
         value_fine = 6'($urandom);
         out_ready  = ((cyc / 100) % 2 == 1) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
         clear      = ($urandom % 64) == 0;
         reset_n    = ($urandom % 128) != 0;
         step();
         n_cmp++; if (out_valid !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, out_valid, mq.size() > 0); end
         n_cmp++; if (fifo_level !== 4'(mq.size())) begin n_err++; $display("FAIL rnd_level cyc %0d: got %0d want %0d", cyc, fifo_level, mq.size()); end
         n_cmp++; if (drop_count !== 16'(m_drop)) begin n_err++; $display("FAIL rnd_drop cyc %0d: got %0d want %0d", cyc, drop_count, m_drop); end
         if (mq.size() > 0) begin
            n_cmp++; if (out_data !== mq[0]) begin n_err++; $display("FAIL rnd_data cyc %0d: got %h want %h", cyc, out_data, mq[0]); end
         end
         if (!reset_n) begin
            n_cmp++; if (out_data !== 30'd0) begin n_err++; $display("FAIL rnd_rst_data cyc %0d: got %h want 0", cyc, out_data); end
         end
      end
      reset_n = 1'b1; clear = 1'b0; fine_valid = 1'b0; out_ready = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b0; fine_valid = 1'b0; value_fine = '0;
      clear = 1'b0; out_ready = 1'b0;
      reset2_n = 1'b0; enable2 = 1'b0; fv2 = 1'b0; vf2 = '0; clear2 = 1'b0; ready2 = 1'b0;
      #1;
      test_reset();
      test_coarse_wrap();
      test_back_to_back();
      test_overflow();
      test_full_pop();
      test_clear_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule : tb_tdc_timestamp_assembler
`default_nettype wire
